// File: rtl/adder_requester.sv
// AXI-Stream initiator: sends an operand pair to an adder endpoint, collects the
// single-beat sum, self-checks it and keeps saturating pass/fail counters.
module adder_requester #(
  parameter int unsigned TDATAW  = 32,
  parameter int unsigned TDESTW  = 4,
  parameter int unsigned TIDW    = 2,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNTW    = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [TDATAW-1:0] REQ_A,
  input  logic [TDATAW-1:0] REQ_B,
  input  logic [TDESTW-1:0] REQ_DEST,
  input  logic [TIDW-1:0]   REQ_ID,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TIDW-1:0]   AXIS_M_TID,
  output logic [TDESTW-1:0] AXIS_M_TDEST,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TIDW-1:0]   AXIS_S_TID,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic              RSP_VALID,
  output logic [TDATAW-1:0] RSP_DATA,
  output logic              RSP_ERR,
  output logic              RSP_TIMEOUT,
  output logic [CNTW-1:0]   PASS_CNT,
  output logic [CNTW-1:0]   FAIL_CNT
);

  localparam int unsigned TMRW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_RSP, REPORT} state_t;

  state_t            state_q, state_d;
  logic [TDATAW-1:0] b_q, b_d, exp_q, exp_d;
  logic [TMRW-1:0]   tmr_q, tmr_d;
  logic              m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
  logic [TDATAW-1:0] m_tdata_q, m_tdata_d;
  logic [TIDW-1:0]   m_tid_q, m_tid_d;
  logic [TDESTW-1:0] m_tdest_q, m_tdest_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_tmo_q, rsp_tmo_d;
  logic [TDATAW-1:0] rsp_data_q, rsp_data_d;
  logic [CNTW-1:0]   pass_q, pass_d, fail_q, fail_d;

  // Response sideband carries nothing this block needs.
  logic unused_s_side;
  assign unused_s_side = ^{AXIS_S_TLAST, AXIS_S_TID, AXIS_S_TDEST};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      b_q         <= '0;
      exp_q       <= '0;
      tmr_q       <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tid_q     <= '0;
      m_tdest_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      exp_q       <= exp_d;
      tmr_q       <= tmr_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      m_tlast_q   <= m_tlast_d;
      m_tid_q     <= m_tid_d;
      m_tdest_q   <= m_tdest_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state and next registered-output values; report fields are loaded on entry to REPORT.
  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    exp_d       = exp_q;
    tmr_d       = tmr_q;
    m_tvalid_d  = m_tvalid_q;
    m_tdata_d   = m_tdata_q;
    m_tlast_d   = m_tlast_q;
    m_tid_d     = m_tid_q;
    m_tdest_d   = m_tdest_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          b_d        = REQ_B;
          exp_d      = REQ_A + REQ_B;
          m_tvalid_d = 1'b1;
          m_tdata_d  = REQ_A;
          m_tlast_d  = 1'b0;
          m_tid_d    = REQ_ID;
          m_tdest_d  = REQ_DEST;
          state_d    = SEND_A;
        end
      end
      SEND_A: begin
        if (AXIS_M_TREADY) begin
          m_tdata_d = b_q;
          m_tlast_d = 1'b1;
          state_d   = SEND_B;
        end
      end
      SEND_B: begin
        if (AXIS_M_TREADY) begin
          m_tvalid_d = 1'b0;
          m_tdata_d  = '0;
          m_tlast_d  = 1'b0;
          m_tid_d    = '0;
          m_tdest_d  = '0;
          tmr_d      = '0;
          state_d    = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        tmr_d = tmr_q + TMRW'(1);
        // A beat in the final waiting cycle takes priority over the timeout.
        if (AXIS_S_TVALID) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = AXIS_S_TDATA;
          rsp_err_d   = (AXIS_S_TDATA != exp_q);
          rsp_tmo_d   = 1'b0;
          if (AXIS_S_TDATA == exp_q) begin
            if (pass_q != '1) pass_d = pass_q + CNTW'(1);
          end else begin
            if (fail_q != '1) fail_d = fail_q + CNTW'(1);
          end
          state_d = REPORT;
        end else if (tmr_q == TMRW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          rsp_tmo_d   = 1'b1;
          if (fail_q != '1) fail_d = fail_q + CNTW'(1);
          state_d = REPORT;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign REQ_READY     = (state_q == IDLE);
  assign AXIS_S_TREADY = (state_q == WAIT_RSP);
  assign AXIS_M_TVALID = m_tvalid_q;
  assign AXIS_M_TDATA  = m_tdata_q;
  assign AXIS_M_TLAST  = m_tlast_q;
  assign AXIS_M_TID    = m_tid_q;
  assign AXIS_M_TDEST  = m_tdest_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_DATA      = rsp_data_q;
  assign RSP_ERR       = rsp_err_q;
  assign RSP_TIMEOUT   = rsp_tmo_q;
  assign PASS_CNT      = pass_q;
  assign FAIL_CNT      = fail_q;

endmodule

// File: tb/tb_adder_requester.sv
// Scoreboard bench for adder_requester: operand beats and reports are queued at
// request time and popped when the DUT emits them. TIMEOUT=16, CNTW=2.
module tb_adder_requester;

  localparam int unsigned DW = 32;
  localparam int unsigned TMO = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    id;
    logic [3:0]    dest;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic          tmo;
    logic [1:0]    pass;
    logic [1:0]    fail;
    logic [15:0]   lat;
  } rsp_t;

  logic          CLK, RST_N;
  logic          REQ_VALID, REQ_READY;
  logic [DW-1:0] REQ_A, REQ_B;
  logic [3:0]    REQ_DEST;
  logic [1:0]    REQ_ID;
  logic          AXIS_M_TVALID, AXIS_M_TREADY, AXIS_M_TLAST;
  logic [DW-1:0] AXIS_M_TDATA;
  logic [1:0]    AXIS_M_TID;
  logic [3:0]    AXIS_M_TDEST;
  logic          AXIS_S_TVALID, AXIS_S_TREADY, AXIS_S_TLAST;
  logic [DW-1:0] AXIS_S_TDATA;
  logic [1:0]    AXIS_S_TID;
  logic [3:0]    AXIS_S_TDEST;
  logic          RSP_VALID, RSP_ERR, RSP_TIMEOUT;
  logic [DW-1:0] RSP_DATA;
  logic [1:0]    PASS_CNT, FAIL_CNT;

  adder_requester #(.TDATAW(DW), .TDESTW(4), .TIDW(2), .TIMEOUT(TMO), .CNTW(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .REQ_DEST(REQ_DEST), .REQ_ID(REQ_ID),
    .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY), .AXIS_M_TDATA(AXIS_M_TDATA),
    .AXIS_M_TLAST(AXIS_M_TLAST), .AXIS_M_TID(AXIS_M_TID), .AXIS_M_TDEST(AXIS_M_TDEST),
    .AXIS_S_TVALID(AXIS_S_TVALID), .AXIS_S_TREADY(AXIS_S_TREADY), .AXIS_S_TDATA(AXIS_S_TDATA),
    .AXIS_S_TLAST(AXIS_S_TLAST), .AXIS_S_TID(AXIS_S_TID), .AXIS_S_TDEST(AXIS_S_TDEST),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  beat_t       exp_beats[$];
  rsp_t        exp_rsp[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          b_cyc = 0;
  logic [1:0]  m_pass = '0;
  logic [1:0]  m_fail = '0;
  bit          hold_chk = 1'b0;
  logic [63:0] hold_val = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Observe the cycle just before the edge, then advance one clock.
  task automatic tick();
    beat_t b;
    rsp_t  r;
    if (hold_chk)
      check_eq("m_hold", 64'({AXIS_M_TVALID, AXIS_M_TDATA, AXIS_M_TLAST, AXIS_M_TID, AXIS_M_TDEST}), hold_val);
    hold_chk = AXIS_M_TVALID && !AXIS_M_TREADY;
    hold_val = 64'({AXIS_M_TVALID, AXIS_M_TDATA, AXIS_M_TLAST, AXIS_M_TID, AXIS_M_TDEST});
    if (!AXIS_M_TVALID)
      check_eq("m_idle_zero", 64'({AXIS_M_TDATA, AXIS_M_TLAST, AXIS_M_TID, AXIS_M_TDEST}), 64'd0);
    if (AXIS_M_TVALID && AXIS_M_TREADY) begin
      check_eq("beat_expected", 64'(exp_beats.size() != 0), 64'd1);
      if (exp_beats.size() != 0) begin
        b = exp_beats.pop_front();
        check_eq("m_tdata", 64'(AXIS_M_TDATA), 64'(b.data));
        check_eq("m_meta", 64'({AXIS_M_TLAST, AXIS_M_TID, AXIS_M_TDEST}), 64'({b.last, b.id, b.dest}));
      end
    end
    if (RSP_VALID) begin
      check_eq("rsp_expected", 64'(exp_rsp.size() != 0), 64'd1);
      if (exp_rsp.size() != 0) begin
        r = exp_rsp.pop_front();
        check_eq("rsp_data", 64'(RSP_DATA), 64'(r.data));
        check_eq("rsp_flags", 64'({RSP_ERR, RSP_TIMEOUT}), 64'({r.err, r.tmo}));
        check_eq("counters", 64'({PASS_CNT, FAIL_CNT}), 64'({r.pass, r.fail}));
        check_eq("rsp_latency", 64'(cyc - b_cyc), 64'(r.lat));
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic run_txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] dest,
                         input logic [1:0] id, input int stall, input bit respond,
                         input logic [DW-1:0] rsp, input int dly, input bit rst_b);
    logic [DW-1:0] sum;
    rsp_t r;
    beat_t bt;
    int n, wcnt, s_at;
    bit sent_b, got_s, aborted;
    n = 0;
    while (!REQ_READY && n < 20) begin tick(); n++; end
    check_eq("req_ready", 64'(REQ_READY), 64'd1);
    sum = a + b;
    bt.data = a; bt.last = 1'b0; bt.id = id; bt.dest = dest; exp_beats.push_back(bt);
    bt.data = b; bt.last = 1'b1; exp_beats.push_back(bt);
    if (respond) begin
      r.data = rsp; r.err = (rsp != sum); r.tmo = 1'b0; r.lat = 16'(dly + 2);
      if (rsp == sum) begin if (m_pass != 2'b11) m_pass++; end
      else begin if (m_fail != 2'b11) m_fail++; end
    end else begin
      r.data = '0; r.err = 1'b0; r.tmo = 1'b1; r.lat = 16'(TMO + 1);
      if (m_fail != 2'b11) m_fail++;
    end
    r.pass = m_pass; r.fail = m_fail;
    exp_rsp.push_back(r);
    REQ_VALID = 1'b1; REQ_A = a; REQ_B = b; REQ_DEST = dest; REQ_ID = id;
    AXIS_M_TREADY = 1'b0;
    tick();
    REQ_VALID = 1'b0; REQ_A = '0; REQ_B = '0; REQ_DEST = '0; REQ_ID = '0;
    n = 0; wcnt = 0; s_at = 0; sent_b = 0; got_s = 0; aborted = 0;
    while (exp_rsp.size() != 0 && n < 200 && !aborted) begin
      AXIS_M_TREADY = 1'b0;
      if (AXIS_M_TVALID) begin
        if (rst_b && AXIS_M_TLAST) begin
          RST_N = 1'b0;
          #2;
          check_eq("rst_m", 64'({AXIS_M_TVALID, AXIS_M_TDATA, AXIS_M_TLAST, AXIS_M_TID, AXIS_M_TDEST}), 64'd0);
          check_eq("rst_rsp", 64'({RSP_VALID, RSP_DATA, RSP_ERR, RSP_TIMEOUT}), 64'd0);
          check_eq("rst_cnt", 64'({PASS_CNT, FAIL_CNT}), 64'd0);
          exp_beats.delete(); exp_rsp.delete();
          m_pass = '0; m_fail = '0; hold_chk = 1'b0;
          @(posedge CLK); #1; cyc++;
          RST_N = 1'b1;
          aborted = 1;
        end else if (wcnt < stall) begin
          wcnt++;
          check_eq("req_ready_busy", 64'(REQ_READY), 64'd0);
        end else begin
          AXIS_M_TREADY = 1'b1;
          wcnt = 0;
          if (AXIS_M_TLAST) begin sent_b = 1; b_cyc = cyc; s_at = cyc + 1 + dly; end
        end
      end
      AXIS_S_TVALID = respond && sent_b && !got_s && (cyc >= s_at);
      AXIS_S_TDATA  = AXIS_S_TVALID ? rsp : '0;
      if (!aborted) begin
        if (AXIS_S_TVALID && AXIS_S_TREADY) got_s = 1;
        tick();
        n++;
      end
    end
    AXIS_S_TVALID = 1'b0; AXIS_S_TDATA = '0; AXIS_M_TREADY = 1'b0;
    if (!aborted) check_eq("txn_complete", 64'(exp_rsp.size()), 64'd0);
    exp_rsp.delete(); exp_beats.delete();
  endtask

  initial begin
    logic [DW-1:0] ra, rb, rs;
    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_A = '0; REQ_B = '0; REQ_DEST = '0; REQ_ID = '0;
    AXIS_M_TREADY = 1'b0; AXIS_S_TVALID = 1'b0; AXIS_S_TDATA = '0;
    AXIS_S_TLAST = 1'b1; AXIS_S_TID = '0; AXIS_S_TDEST = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("reset_ready", 64'({REQ_READY, AXIS_S_TREADY}), 64'b10);
    check_eq("reset_m", 64'({AXIS_M_TVALID, AXIS_M_TDATA, AXIS_M_TLAST, AXIS_M_TID, AXIS_M_TDEST}), 64'd0);
    check_eq("reset_rsp", 64'({RSP_VALID, RSP_DATA, RSP_ERR, RSP_TIMEOUT, PASS_CNT, FAIL_CNT}), 64'd0);
    RST_N = 1'b1;
    tick();

    run_txn(32'd5, 32'd7, 4'h1, 2'd2, 0, 1'b1, 32'd12, 3, 1'b0);
    run_txn(32'hFFFF_FFFF, 32'd2, 4'h3, 2'd1, 0, 1'b1, 32'd1, 0, 1'b0);
    run_txn(32'd1, 32'd1, 4'h5, 2'd0, 0, 1'b1, 32'd3, 2, 1'b0);
    run_txn(32'd10, 32'd20, 4'hA, 2'd3, 4, 1'b1, 32'd30, 1, 1'b0);
    run_txn(32'd40, 32'd2, 4'h2, 2'd1, 0, 1'b0, 32'd0, 0, 1'b0);
    run_txn(32'd100, 32'd23, 4'h7, 2'd2, 0, 1'b1, 32'd123, TMO - 1, 1'b0);
    run_txn(32'hDEAD_0000, 32'h0000_BEEF, 4'h9, 2'd1, 0, 1'b1, 32'd0, 0, 1'b1);
    run_txn(32'd1, 32'd2, 4'h4, 2'd0, 0, 1'b1, 32'd3, 2, 1'b0);
    check_eq("post_reset_pass", 64'({PASS_CNT, FAIL_CNT}), 64'({2'd1, 2'd0}));
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = ra + rb;
      if (i == 2) rs = rs ^ 32'h1;
      run_txn(ra, rb, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 2), 1'b1, rs, $urandom_range(0, 6), 1'b0);
    end
    check_eq("final_counters", 64'({PASS_CNT, FAIL_CNT}), 64'({2'd3, 2'd1}));
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/adder_requester.md
Name: adder_requester

Overview:
- AXI-Stream initiator that drives operand pairs into the NoC toward an adder endpoint, then collects that endpoint's single-beat result.
- Checks each result against a locally computed sum; reports pass, fail or timeout per transaction and keeps saturating pass/fail counters.
- Sits at a NoC tile as traffic source and self-checker for adder endpoints.

Parameters:
TDATAW, 32, data width of operands, result and AXIS TDATA
TDESTW, 4, AXIS TDEST width
TIDW, 2, AXIS TID width
TIMEOUT, 1024, max cycles in WAIT_RSP before declaring timeout (>=2)
CNTW, 16, width of pass/fail counters

Ports:
CLK  in  1  clock
RST_N  in  1  reset
REQ_VALID  in  1  request present
REQ_READY  out  1  block can accept a request
REQ_A  in  TDATAW  first operand
REQ_B  in  TDATAW  second operand
REQ_DEST  in  TDESTW  target adder TDEST
REQ_ID  in  TIDW  transaction TID
AXIS_M_TVALID  out  1  master beat valid
AXIS_M_TREADY  in  1  master beat accepted
AXIS_M_TDATA  out  TDATAW  operand beat
AXIS_M_TLAST  out  1  high on second operand beat
AXIS_M_TID  out  TIDW  latched REQ_ID
AXIS_M_TDEST  out  TDESTW  latched REQ_DEST
AXIS_S_TVALID  in  1  result beat valid
AXIS_S_TREADY  out  1  result beat accepted
AXIS_S_TDATA  in  TDATAW  result value
AXIS_S_TLAST  in  1  ignored for acceptance; expected 1
AXIS_S_TID  in  TIDW  ignored
AXIS_S_TDEST  in  TDESTW  ignored
RSP_VALID  out  1  one-cycle transaction-complete pulse
RSP_DATA  out  TDATAW  received result (0 on timeout)
RSP_ERR  out  1  result != expected, qualified by RSP_VALID
RSP_TIMEOUT  out  1  no result within TIMEOUT, qualified by RSP_VALID
PASS_CNT  out  CNTW  matching results count
FAIL_CNT  out  CNTW  mismatches plus timeouts count

Behaviour:
- Reset: RST_N is asynchronous, active-low; CLK is the clock. All outputs, registers and counters reset to 0; state IDLE.
- Reset mid-transaction aborts immediately: TVALID drops, nothing reported, counters cleared.
- All outputs registered except REQ_READY = (state==IDLE) and AXIS_S_TREADY = (state==WAIT_RSP).
- IDLE: on REQ_VALID&&REQ_READY, latch A, B, DEST, ID and expected = (A+B) mod 2^TDATAW, carry dropped; go SEND_A next cycle.
- SEND_A: TVALID=1, TDATA=A, TLAST=0. Hold all M signals stable until TREADY; on TREADY go SEND_B.
- SEND_B: TVALID=1, TDATA=B, TLAST=1, same TID/TDEST; on TREADY go WAIT_RSP, TVALID low next cycle unless a new beat.
- Minimum two cycles from request accept to last operand beat with TREADY tied high; back-to-back beats permitted, no idle cycle between A and B.
- WAIT_RSP: timeout counter starts at 0 on entry, increments each cycle. On AXIS_S_TVALID (TREADY high), capture TDATA, go REPORT. If counter reaches TIMEOUT-1 with no beat, go REPORT with timeout set; a beat arriving in that same final cycle wins over timeout.
- REPORT (one cycle): RSP_VALID=1; RSP_DATA, RSP_ERR=(data!=expected), RSP_TIMEOUT set accordingly. PASS_CNT+1 on match, else FAIL_CNT+1; both saturate at 2^CNTW-1. Return to IDLE.
- RSP_ERR and RSP_TIMEOUT never both high.
- M interface: TDATA/TLAST/TID/TDEST are 0 whenever TVALID=0.
- Late result arriving after timeout is accepted in IDLE? No: TREADY is low outside WAIT_RSP; the stray beat stays stalled until the next transaction's WAIT_RSP. Documented limitation.
- One transaction outstanding at a time; throughput bounded by round trip plus 2 cycles.

Test Plan:
- A=5, B=7, DEST=4'h1, ID=2, TREADY high, result 12 returned 3 cycles after TLAST -> beats 5 (TLAST 0), 7 (TLAST 1), TDEST 1, TID 2; RSP_VALID pulse, RSP_DATA=12, RSP_ERR=0, PASS_CNT=1.
- A=32'hFFFFFFFF, B=2, result 1 -> RSP_ERR=0 (wrap); then result 3 for A=1,B=1 -> RSP_ERR=1, FAIL_CNT=1.
- AXIS_M_TREADY low for 4 cycles on each beat -> TVALID, TDATA, TLAST held stable throughout; REQ_READY stays 0.
- No result, TIMEOUT=16 -> RSP_VALID with RSP_TIMEOUT=1, RSP_DATA=0 exactly 16 cycles after WAIT_RSP entry; FAIL_CNT increments; result on cycle 16 instead -> normal report, no timeout.
- Assert RST_N low during SEND_B with TVALID high -> all outputs 0 asynchronously; after release, new request A=1,B=2 completes normally with PASS_CNT=1.
- CNTW=2, four matching transactions -> PASS_CNT saturates at 3.
